// File: rtl/axi4_lite_reg_slave.sv
// AXI4-Lite slave exposing eight 32-bit registers in a 32-byte window at BASE_ADDR.
// Define AXI4_LITE_REG_SLVERR_EN to range-check addresses and answer SLVERR outside the window.
module axi4_lite_reg_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] axi_awaddr,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [2:0]  axi_awprot,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready,
    input  logic [31:0] axi_araddr,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    input  logic [2:0]  axi_arprot,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rvalid,
    input  logic        axi_rready
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {IDLE, HAVE_AW, HAVE_W, COMMIT, RESP} wr_state_e;

    wr_state_e   wr_state_q;
    logic [31:0] regs_q [8];
    logic [2:0]  aw_idx_q;
    logic        aw_ok_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic        rvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q;
    logic [31:0] wr_merged_d;
    logic        aw_in_range;
    logic        ar_in_range;
    logic        aw_hs;
    logic        w_hs;
    logic        ar_hs;

    // Protection bits and the ignored address bits are intentionally dropped.
    logic unused_inputs;
    assign unused_inputs = ^{axi_awprot, axi_arprot, axi_awaddr, axi_araddr, BASE_ADDR};

`ifdef AXI4_LITE_REG_SLVERR_EN
    assign aw_in_range = (axi_awaddr[31:5] == BASE_ADDR[31:5]);
    assign ar_in_range = (axi_araddr[31:5] == BASE_ADDR[31:5]);
`else
    assign aw_in_range = 1'b1;
    assign ar_in_range = 1'b1;
`endif

    assign axi_awready = aresetn && (wr_state_q == IDLE || wr_state_q == HAVE_W);
    assign axi_wready  = aresetn && (wr_state_q == IDLE || wr_state_q == HAVE_AW);
    assign axi_arready = aresetn && !rvalid_q;

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    assign ar_hs = axi_arvalid && axi_arready;

    assign axi_bvalid = bvalid_q;
    assign axi_bresp  = bresp_q;
    assign axi_rvalid = rvalid_q;
    assign axi_rdata  = rdata_q;
    assign axi_rresp  = rresp_q;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign wr_merged_d[8*gi +: 8] = wstrb_q[gi] ? wdata_q[8*gi +: 8]
                                                        : regs_q[aw_idx_q][8*gi +: 8];
        end
    endgenerate

    // Handshakes can only occur in states whose ready is high, so capture is unconditional.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_state_q <= IDLE;
            aw_idx_q   <= '0;
            aw_ok_q    <= 1'b0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= RESET_VALUE;
            end
        end else begin
            if (aw_hs) begin
                aw_idx_q <= axi_awaddr[4:2];
                aw_ok_q  <= aw_in_range;
            end
            if (w_hs) begin
                wdata_q <= axi_wdata;
                wstrb_q <= axi_wstrb;
            end
            case (wr_state_q)
                IDLE: begin
                    if (aw_hs && w_hs) begin
                        wr_state_q <= COMMIT;
                    end else if (aw_hs) begin
                        wr_state_q <= HAVE_AW;
                    end else if (w_hs) begin
                        wr_state_q <= HAVE_W;
                    end
                end
                HAVE_AW: if (w_hs)  wr_state_q <= COMMIT;
                HAVE_W:  if (aw_hs) wr_state_q <= COMMIT;
                COMMIT: begin
                    if (aw_ok_q) begin
                        regs_q[aw_idx_q] <= wr_merged_d;
                    end
                    bvalid_q   <= 1'b1;
                    bresp_q    <= aw_ok_q ? RESP_OKAY : RESP_SLVERR;
                    wr_state_q <= RESP;
                end
                RESP: begin
                    if (axi_bready) begin
                        bvalid_q   <= 1'b0;
                        wr_state_q <= IDLE;
                    end
                end
                default: wr_state_q <= IDLE;
            endcase
        end
    end

    // A read on the commit edge samples regs_q before the nonblocking update lands.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (ar_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= ar_in_range ? regs_q[axi_araddr[4:2]] : '0;
            rresp_q  <= ar_in_range ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && axi_rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4_lite_reg_slave.sv
// Directed bench for axi4_lite_reg_slave: a transaction-level register model checks every cycle,
// and literal expectations pin individual transactions.
module tb_axi4_lite_reg_slave;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam logic [31:0] RSTV  = 32'h0000_0000;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] axi_awaddr;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [2:0]  axi_awprot;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;
    logic [31:0] axi_araddr;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [2:0]  axi_arprot;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rvalid;
    logic        axi_rready;

    int n_pass  = 0;
    int n_total = 0;

    axi4_lite_reg_slave #(.BASE_ADDR(BASE), .RESET_VALUE(RSTV)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_awprot(axi_awprot),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid),
        .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_arprot(axi_arprot),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready)
    );

    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_total++;
        $display("FAIL %s: timed out waiting for DUT (t=%0t)", name, $time);
    endtask

    function automatic bit in_window(input logic [31:0] a);
        bit r;
        r = (a[31:5] == BASE[31:5]);
`ifndef AXI4_LITE_REG_SLVERR_EN
        r = 1'b1;
`endif
        return r;
    endfunction

    // ---------------- transaction-level model ----------------
    logic [31:0] m_regs [8];
    bit          m_have_aw, m_have_w, m_commit;
    logic [31:0] m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    bit          e_bvalid, e_rvalid;
    logic [1:0]  e_bresp, e_rresp;
    logic [31:0] e_rdata;

    // Inputs change just after rising edges, so at the falling edge both the current outputs and
    // the inputs the next rising edge will see are stable.
    always @(negedge aclk) begin
        bit exp_awr, exp_wr, aw_hs, w_hs, ar_hs;
        int idx;
        if (!aresetn) begin
            chk("awready_in_reset", {31'd0, axi_awready}, 32'd0);
            chk("wready_in_reset",  {31'd0, axi_wready},  32'd0);
            chk("arready_in_reset", {31'd0, axi_arready}, 32'd0);
            for (int i = 0; i < 8; i++) m_regs[i] = RSTV;
            m_have_aw = 0; m_have_w = 0; m_commit = 0;
            e_bvalid = 0; e_rvalid = 0;
        end else begin
            exp_awr = !m_have_aw && !m_commit && !e_bvalid;
            exp_wr  = !m_have_w  && !m_commit && !e_bvalid;
            chk("bvalid", {31'd0, axi_bvalid}, {31'd0, e_bvalid});
            if (e_bvalid) chk("bresp", {30'd0, axi_bresp}, {30'd0, e_bresp});
            chk("rvalid", {31'd0, axi_rvalid}, {31'd0, e_rvalid});
            if (e_rvalid) begin
                chk("rdata", axi_rdata, e_rdata);
                chk("rresp", {30'd0, axi_rresp}, {30'd0, e_rresp});
            end
            chk("awready", {31'd0, axi_awready}, {31'd0, exp_awr});
            chk("wready",  {31'd0, axi_wready},  {31'd0, exp_wr});
            chk("arready", {31'd0, axi_arready}, {31'd0, !e_rvalid});

            aw_hs = axi_awvalid && exp_awr;
            w_hs  = axi_wvalid && exp_wr;
            ar_hs = axi_arvalid && !e_rvalid;
            if (ar_hs) begin
                e_rvalid = 1;
                idx = int'(axi_araddr[4:2]);
                e_rdata = in_window(axi_araddr) ? m_regs[idx] : 32'd0;
                e_rresp = in_window(axi_araddr) ? 2'b00 : 2'b10;
            end else if (e_rvalid && axi_rready) begin
                e_rvalid = 0;
            end
            if (e_bvalid && axi_bready) e_bvalid = 0;
            if (m_commit) begin
                idx = int'(m_awaddr[4:2]);
                if (in_window(m_awaddr))
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) m_regs[idx][8*b +: 8] = m_wdata[8*b +: 8];
                e_bvalid = 1;
                e_bresp  = in_window(m_awaddr) ? 2'b00 : 2'b10;
                m_commit = 0;
            end
            if (aw_hs) begin m_have_aw = 1; m_awaddr = axi_awaddr; end
            if (w_hs)  begin m_have_w = 1; m_wdata = axi_wdata; m_wstrb = axi_wstrb; end
            if (m_have_aw && m_have_w) begin
                m_commit = 1; m_have_aw = 0; m_have_w = 0;
            end
        end
    end

    // ---------------- drivers (entered and left just after a rising edge) ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int w_delay, input int b_delay,
                             output logic [1:0] resp, output int lat);
        bit aw_ok = 0, w_ok = 0, a_now, w_now, got_b = 0;
        int cyc = 0;
        resp = 2'bxx; lat = 0;
        axi_awaddr = addr; axi_awvalid = 1'b1;
        axi_wdata = data; axi_wstrb = strb; axi_wvalid = (w_delay == 0);
        while (!(aw_ok && w_ok) && cyc < 50) begin
            @(negedge aclk);
            a_now = axi_awvalid && axi_awready;
            w_now = axi_wvalid && axi_wready;
            @(posedge aclk); #1;
            if (a_now) begin aw_ok = 1; axi_awvalid = 1'b0; end
            if (w_now) begin w_ok = 1; axi_wvalid = 1'b0; end
            cyc++;
            if (!w_ok && !axi_wvalid && cyc >= w_delay) axi_wvalid = 1'b1;
        end
        axi_awvalid = 1'b0; axi_wvalid = 1'b0;
        if (!(aw_ok && w_ok)) begin timeout("write_handshake"); return; end
        while (!got_b && lat < 50) begin
            @(negedge aclk);
            lat++;
            if (axi_bvalid) begin got_b = 1; resp = axi_bresp; end
            @(posedge aclk); #1;
        end
        if (!got_b) begin timeout("write_bvalid"); return; end
        repeat (b_delay) begin @(posedge aclk); #1; end
        axi_bready = 1'b1;
        @(posedge aclk); #1;
        axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
        bit ok = 0;
        data = 32'hxxxx_xxxx; resp = 2'bxx;
        axi_araddr = addr; axi_arvalid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            if (axi_arready) ok = 1;
            @(posedge aclk); #1;
        end
        axi_arvalid = 1'b0;
        if (!ok) begin timeout("read_handshake"); return; end
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge aclk);
            if (axi_rvalid) begin ok = 1; data = axi_rdata; resp = axi_rresp; end
            @(posedge aclk); #1;
        end
        if (!ok) timeout("read_rvalid");
    endtask

    logic [31:0] rd0, rd1;
    logic [1:0]  rr0, rr1, br;
    int          lat;

    initial begin
        aresetn = 1'b0;
        axi_awaddr = '0; axi_awvalid = 1'b0; axi_awprot = 3'b000;
        axi_wdata = '0; axi_wstrb = '0; axi_wvalid = 1'b0;
        axi_bready = 1'b0;
        axi_araddr = '0; axi_arvalid = 1'b0; axi_arprot = 3'b000;
        axi_rready = 1'b1;
        repeat (3) @(posedge aclk);
        #1 aresetn = 1'b1;

        @(negedge aclk);
        chk("post_reset_awready", {31'd0, axi_awready}, 32'd1);
        chk("post_reset_wready",  {31'd0, axi_wready},  32'd1);
        chk("post_reset_arready", {31'd0, axi_arready}, 32'd1);
        chk("post_reset_bvalid",  {31'd0, axi_bvalid},  32'd0);
        chk("post_reset_rvalid",  {31'd0, axi_rvalid},  32'd0);
        chk("post_reset_rdata",   axi_rdata, 32'd0);
        chk("post_reset_bresp",   {30'd0, axi_bresp}, 32'd0);
        chk("post_reset_rresp",   {30'd0, axi_rresp}, 32'd0);
        @(posedge aclk); #1;

        // AW first, W three cycles later
        axi_write(32'h1000, 32'h1234_5678, 4'hF, 3, 0, br, lat);
        chk("wr1000_bresp", {30'd0, br}, 32'd0);
        axi_read(32'h1000, rd0, rr0);
        chk("rd1000_data", rd0, 32'h1234_5678);
        chk("rd1000_resp", {30'd0, rr0}, 32'd0);

        // AW and W together, sparse strobes
        axi_write(32'h1004, 32'hAABB_CCDD, 4'b0101, 0, 0, br, lat);
        chk("wr1004_latency", lat, 32'd2);
        chk("wr1004_bresp", {30'd0, br}, 32'd0);
        axi_read(32'h1004, rd0, rr0);
        chk("rd1004_data", rd0, 32'h00BB_00DD);

        // Held-off B response with a concurrent read
        fork
            axi_write(32'h100C, 32'h0000_0055, 4'hF, 0, 5, br, lat);
            begin
                repeat (3) begin @(posedge aclk); #1; end
                axi_read(32'h1008, rd1, rr1);
            end
        join
        chk("wr100C_bresp", {30'd0, br}, 32'd0);
        chk("rd1008_concurrent", rd1, 32'd0);
        chk("rd1008_resp", {30'd0, rr1}, 32'd0);

        // Read captured on the commit edge returns the old value
        axi_write(32'h101C, 32'h1, 4'hF, 0, 0, br, lat);
        fork
            axi_write(32'h101C, 32'h2, 4'hF, 0, 0, br, lat);
            begin
                @(posedge aclk); #1;
                axi_read(32'h101C, rd1, rr1);
            end
        join
        chk("rd101C_on_commit", rd1, 32'h1);
        axi_read(32'h101C, rd0, rr0);
        chk("rd101C_after", rd0, 32'h2);

        // Out-of-window access
        axi_write(32'h2000, 32'hFFFF_FFFF, 4'hF, 0, 0, br, lat);
`ifdef AXI4_LITE_REG_SLVERR_EN
        chk("wr2000_bresp", {30'd0, br}, 32'd2);
        axi_read(32'h2000, rd0, rr0);
        chk("rd2000_data", rd0, 32'd0);
        chk("rd2000_resp", {30'd0, rr0}, 32'd2);
        axi_read(32'h1000, rd0, rr0);
        chk("rd1000_untouched", rd0, 32'h1234_5678);
`else
        chk("wr2000_bresp", {30'd0, br}, 32'd0);
        axi_read(32'h1000, rd0, rr0);
        chk("rd1000_aliased", rd0, 32'hFFFF_FFFF);
`endif

        // Reset while holding only the write address
        axi_awaddr = 32'h1014; axi_awvalid = 1'b1;
        @(negedge aclk);
        chk("aw_only_ready", {31'd0, axi_awready}, 32'd1);
        @(posedge aclk); #1;
        axi_awvalid = 1'b0;
        aresetn = 1'b0;
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (3) begin
            @(negedge aclk);
            chk("bvalid_after_abort", {31'd0, axi_bvalid}, 32'd0);
            @(posedge aclk); #1;
        end
        for (int i = 0; i < 8; i++) begin
            axi_read(BASE + 32'(4 * i), rd0, rr0);
            chk($sformatf("reg%0d_after_reset", i), rd0, RSTV);
        end
        axi_write(32'h1014, 32'hCAFE_F00D, 4'hF, 0, 0, br, lat);
        chk("wr1014_bresp", {30'd0, br}, 32'd0);
        axi_read(32'h1014, rd0, rr0);
        chk("rd1014_data", rd0, 32'hCAFE_F00D);

        repeat (2) @(posedge aclk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
